// File: rtl/frame_min_max_tracker.sv
// frame_min_max_tracker: per-frame unsigned max/min with first-occurrence indices and all-equal flag
module frame_min_max_tracker #(
  parameter int N = 4,
  parameter int FRAME_LEN = 8,
  parameter int IDX_W = $clog2(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N-1:0]     max_val,
  output logic [N-1:0]     min_val,
  output logic [IDX_W-1:0] max_idx,
  output logic [IDX_W-1:0] min_idx,
  output logic             all_equal,
  output logic             busy
);
  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(FRAME_LEN - 1);
  state_t state;
  logic [IDX_W-1:0] cnt;
  logic [N-1:0] s0;
  assign in_ready = state == ACCUM;
  assign out_valid = state == DONE;
  assign busy = state != IDLE;
  // sample 0 is kept separately because min/max move away from it
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      s0 <= '0;
      max_val <= '0;
      min_val <= '0;
      max_idx <= '0;
      min_idx <= '0;
      all_equal <= 1'b0;
    end else case (state)
      IDLE: if (start) begin
        state <= ACCUM;
        cnt <= '0;
      end
      ACCUM: if (in_valid) begin
        cnt <= cnt + IDX_W'(1);
        if (cnt == '0) begin
          s0 <= in_data;
          max_val <= in_data;
          min_val <= in_data;
          max_idx <= '0;
          min_idx <= '0;
          all_equal <= 1'b1;
        end else begin
          if (in_data > max_val) begin
            max_val <= in_data;
            max_idx <= cnt;
          end
          if (in_data < min_val) begin
            min_val <= in_data;
            min_idx <= cnt;
          end
          if (in_data != s0) all_equal <= 1'b0;
        end
        if (cnt == LAST) state <= DONE;
      end
      DONE: if (out_ready) state <= IDLE;
      default: state <= IDLE;
    endcase
endmodule

// File: tb/tb_frame_min_max_tracker.sv
// tb_frame_min_max_tracker: directed and randomized checks against a whole-frame reference model
module tb_frame_min_max_tracker;
  localparam int N = 4, FL = 8, IW = 3, RW = 2 * N + 2 * IW + 1;
  typedef logic [N-1:0] frame_t [FL];
  logic clk = 0, rst = 1, start = 0, in_valid = 0, out_ready = 0;
  logic [N-1:0] in_data = '0;
  logic in_ready, out_valid, all_equal, busy;
  logic [N-1:0] max_val, min_val;
  logic [IW-1:0] max_idx, min_idx;
  logic [RW-1:0] res;
  int checks = 0, fails = 0, early;
  bit timeout;
  frame_min_max_tracker #(.N(N), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .max_val(max_val),
    .min_val(min_val), .max_idx(max_idx), .min_idx(min_idx), .all_equal(all_equal), .busy(busy)
  );
  assign res = {max_val, max_idx, min_val, min_idx, all_equal};
  always #5 clk = ~clk;
  function automatic logic [RW-1:0] model(input frame_t s);
    logic [N-1:0] mx, mn;
    int mxi, mni;
    bit eq;
    mx = s[0]; mn = s[0]; eq = 1; mxi = 0; mni = 0;
    foreach (s[i]) begin
      if (s[i] > mx) mx = s[i];
      if (s[i] < mn) mn = s[i];
      if (s[i] != s[0]) eq = 0;
    end
    for (int i = FL - 1; i >= 0; i--) begin
      if (s[i] == mx) mxi = i;
      if (s[i] == mn) mni = i;
    end
    return {mx, IW'(mxi), mn, IW'(mni), eq};
  endfunction
  // mode 0: continuous valid, 1: alternating valid, 2: random valid
  task automatic drive_frame(input frame_t s, input int mode);
    int k = 0, cyc = 0;
    early = 0;
    start = 1;
    @(negedge clk);
    start = 0;
    while (k < FL && cyc < 200) begin
      in_valid = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      in_data = in_valid ? s[k] : N'($urandom);
      @(negedge clk);
      if (in_valid) k++;
      if (k < FL && out_valid) early++;
      cyc++;
    end
    in_valid = 0;
    timeout = k < FL;
  endtask
  task automatic handshake();
    out_ready = 1;
    @(negedge clk);
    out_ready = 0;
  endtask
  task automatic test_reset();
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy, res} !== '0) begin
      fails++;
      $display("FAIL reset: got %h expected 0", {in_ready, out_valid, busy, res});
    end
    rst = 0;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b000) begin
      fails++;
      $display("FAIL idle_after_reset: got %b expected 000", {in_ready, out_valid, busy});
    end
  endtask
  task automatic test_directed(input string name, input frame_t s, input int mode, input logic [RW-1:0] exp);
    drive_frame(s, mode);
    checks++;
    if ({timeout, early} !== 0 || out_valid !== 1'b1) begin
      fails++;
      $display("FAIL %s_timing: got timeout=%0d early=%0d out_valid=%b expected 0 0 1", name, timeout, early, out_valid);
    end
    checks++;
    if (res !== exp) begin
      fails++;
      $display("FAIL %s_result: got %h expected %h", name, res, exp);
    end
    handshake();
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      fails++;
      $display("FAIL %s_release: got %b expected 00", name, {out_valid, busy});
    end
  endtask
  task automatic test_backpressure();
    frame_t s;
    logic [RW-1:0] exp;
    foreach (s[i]) s[i] = N'($urandom);
    exp = model(s);
    drive_frame(s, 0);
    for (int i = 0; i < 5; i++) begin
      start = 1; in_valid = 1; in_data = N'($urandom); out_ready = 0;
      @(negedge clk);
      checks++;
      if ({in_ready, out_valid, busy, res} !== {3'b011, exp}) begin
        fails++;
        $display("FAIL backpressure_hold: got %h expected %h", {in_ready, out_valid, busy, res}, {3'b011, exp});
      end
    end
    handshake();
    start = 0; in_valid = 0;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b000) begin
      fails++;
      $display("FAIL backpressure_release: got %b expected 000", {in_ready, out_valid, busy});
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || res !== exp) begin
      fails++;
      $display("FAIL start_during_handshake: got busy=%b res=%h expected 0 %h", busy, res, exp);
    end
  endtask
  task automatic test_async_reset();
    frame_t s;
    start = 1;
    @(negedge clk);
    start = 0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1; in_data = N'(i + 3);
      @(negedge clk);
    end
    in_valid = 0;
    #2 rst = 1;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, res} !== '0) begin
      fails++;
      $display("FAIL async_reset: got %h expected 0", {in_ready, out_valid, busy, res});
    end
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({out_valid, busy} !== 2'b00) begin
        fails++;
        $display("FAIL post_reset_idle: got %b expected 00", {out_valid, busy});
      end
    end
    foreach (s[i]) s[i] = N'(i + 1);
    test_directed("after_reset", s, 2, {4'd8, 3'd7, 4'd1, 3'd0, 1'b0});
  endtask
  task automatic test_random();
    frame_t s;
    logic [RW-1:0] exp;
    int lat;
    for (int f = 0; f < 20; f++) begin
      foreach (s[i]) s[i] = f % 3 == 0 ? N'($urandom) : N'($urandom_range(0, 2) + f % 4);
      exp = model(s);
      drive_frame(s, 2);
      lat = $urandom_range(0, 3);
      for (int c = 0; c < lat; c++) begin
        @(negedge clk);
      end
      checks++;
      if (timeout || early != 0 || out_valid !== 1'b1 || res !== exp) begin
        fails++;
        $display("FAIL random_frame%0d: got to=%0d early=%0d ov=%b res=%h expected 0 0 1 %h", f, timeout, early, out_valid, res, exp);
      end
      handshake();
      checks++;
      if (out_valid !== 1'b0) begin
        fails++;
        $display("FAIL random_release%0d: got %b expected 0", f, out_valid);
      end
    end
  endtask
  initial begin
    frame_t s;
    test_reset();
    s = '{3, 9, 1, 9, 7, 1, 0, 15};
    test_directed("basic", s, 0, {4'd15, 3'd7, 4'd0, 3'd6, 1'b0});
    s = '{5, 12, 2, 12, 2, 8, 8, 5};
    test_directed("ties", s, 0, {4'd12, 3'd1, 4'd2, 3'd2, 1'b0});
    s = '{6, 6, 6, 6, 6, 6, 6, 6};
    test_directed("all_equal", s, 1, {4'd6, 3'd0, 4'd6, 3'd0, 1'b1});
    s = '{15, 15, 15, 15, 15, 15, 15, 0};
    test_directed("boundary", s, 0, {4'd15, 3'd0, 4'd0, 3'd7, 1'b0});
    test_backpressure();
    test_async_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/frame_min_max_tracker.md
Name: frame_min_max_tracker

Overview:
- Streaming stage feeding the team's N-bit magnitude comparison path: accepts a frame of FRAME_LEN unsigned N-bit samples over a valid/ready handshake.
- Tracks running maximum, running minimum, their first-occurrence indices, and whether all samples were equal.
- Presents one result record per frame on a valid/ready output port.
- Compare semantics match the existing comparator: unsigned, great/less/equal mutually exclusive.

Parameters:
- N, 4, sample width in bits (>=2, even).
- FRAME_LEN, 8, samples per frame (>=2).
- IDX_W, $clog2(FRAME_LEN), index/counter width (derived; do not override).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a frame; honoured only in IDLE.
- in_valid  in  1  sample present.
- in_ready  out  1  block can accept a sample.
- in_data  in  N  unsigned sample.
- out_valid  out  1  frame result available.
- out_ready  in  1  downstream accepts result.
- max_val  out  N  largest sample of frame.
- min_val  out  N  smallest sample of frame.
- max_idx  out  IDX_W  index (0-based) of first occurrence of max.
- min_idx  out  IDX_W  index of first occurrence of min.
- all_equal  out  1  every sample of frame equal to sample 0.
- busy  out  1  high in ACCUM or DONE.

Behaviour:
- Reset (async, immediate): state=IDLE; in_ready, out_valid, busy, all_equal = 0; max_val, min_val, max_idx, min_idx, sample counter = 0.
- Reset mid-frame or mid-DONE: partial results discarded, no out_valid pulse afterwards.
- States: IDLE, ACCUM, DONE.
- IDLE: in_ready=0, out_valid=0. start=1 -> ACCUM next cycle; counter cleared. Result registers keep the previous frame's values.
- ACCUM: in_ready=1 (combinational from state only, never from in_valid). Accept = in_valid & in_ready.
  - Accept at count 0: max_val=min_val=in_data; max_idx=min_idx=0; all_equal=1.
  - Accept at count k>0: if in_data > max_val, update max_val and max_idx=k. If in_data < min_val, update min_val and min_idx=k. Ties never update (first occurrence wins). If in_data != the registered sample 0 value, clear all_equal (sticky).
  - Counter increments per accept. The accept at count FRAME_LEN-1 moves to DONE next cycle.
  - No accept (in_valid low) leaves state, counter and results unchanged; gaps are unlimited.
- DONE: in_ready=0, out_valid=1, results stable. When out_ready=1, go to IDLE next cycle and drop out_valid.
- out_valid rises exactly one cycle after the final sample accept.
- out_valid & out_ready in the same cycle as DONE entry is a legal one-cycle handshake.
- start is ignored in ACCUM and DONE (no restart, no counter clear).
- start in the same cycle as the DONE->IDLE handshake is ignored; a new start is needed in IDLE.
- Comparisons are unsigned, N-bit, with no width extension. Counter width IDX_W; the counter never wraps within a frame because the exit occurs at FRAME_LEN-1.
- busy = (state != IDLE).

Test Plan:
- Basic frame, N=4, FRAME_LEN=8, samples 3,9,1,9,7,1,0,15 with continuous valid -> out_valid one cycle after 8th accept; max_val=15, max_idx=7, min_val=0, min_idx=6, all_equal=0.
- Ties, samples 5,12,2,12,2,8,8,5 -> max_val=12, max_idx=1; min_val=2, min_idx=2 (first occurrence kept); all_equal=0.
- All equal, eight samples of 6 with in_valid toggling 1/0 each cycle -> 8 accepts over 16 cycles; max=min=6, both idx=0, all_equal=1; out_valid not asserted before the 8th accept.
- Backpressure, hold out_ready=0 for 5 cycles in DONE while driving start and in_valid=1 -> in_ready stays 0; outputs stable; no restart. Then out_ready=1 -> IDLE next cycle, out_valid=0.
- Boundary values 0 and 15, samples 15,15,...,15,0 -> max_idx=0, min_val=0, min_idx=7; confirm no unsigned/sign error.
- Async reset asserted mid-frame after 4 accepts, between clock edges -> all outputs 0 immediately. After release, a new start and 8 samples 1..8 -> max_val=8, max_idx=7, min_val=1, min_idx=0.
